i2c_peripheral: RTL
===================

// Module: i2c_peripheral
// PURPOSE
//  I2C target (responder) pairing with i2c_controller on the shared sdc/sda bus.
//  Oversamples sdc/sda with the system clk and detects START/STOP conditions.
//  Matches a 7-bit address, ACKs, and then does one of two things:
//   - accepts write bytes, or
//   - serves read bytes from a user-supplied tx_byte.
//  sda is open-drain: the block only ever drives 0 or releases it (z).
// PARAMETERS
//  PERIPH_ADDR  7'd5  7-bit address this target answers to
//  SYNC_STAGES  2     synchronizer flops on sdc/sda (>=2)
// PORTS
//  clk        in     1  system clock
//  reset      in     1  asynchronous active-high reset
//  sdc        in     1  I2C serial clock (target never stretches)
//  sda        inout  1  I2C data; driven 1'b0 or 1'bz only
//  tx_byte    in     8  next byte to send on a read; sampled as described below
//  rx_byte    out    8  last byte received in a write transfer
//  rx_valid   out    1  1-clk pulse: rx_byte updated
//  tx_req     out    1  1-clk pulse: supply next tx_byte
//  addressed  out    1  high while this target is selected (ADDR_ACK..stop/restart)
//  rw         out    1  R/W bit of current transfer (1 = controller reads)
// BEHAVIOUR
//  Reset: rx_byte=0, rx_valid=0, tx_req=0, addressed=0, rw=0, sda=z, state=IDLE.
//   Reset is async; asserting it mid-transfer releases sda immediately.
//  Sampling: sdc/sda pass SYNC_STAGES flops; edges come from a registered copy.
//   Each sdc high/low phase must last >= SYNC_STAGES+2 clk.
//  START: sda falls while sdc high -> ADDR from ANY state (repeated start included).
//   bit_cnt=0, sda released, addressed=0.
//  STOP: sda rises while sdc high -> IDLE from any state; sda released, addressed=0.
//  Data is sampled on sdc rising edges, MSB first.
//  The target changes its sda drive only on sdc falling edges.
//  States:
//   IDLE      wait for START.
//   ADDR      shift 8 bits (addr[6:0], rw).
//             After the 8th rise: match -> ADDR_ACK; mismatch -> WAIT_STOP.
//   ADDR_ACK  drive sda=0 from the next sdc fall to the fall after the 9th rise.
//             Latch rw; addressed=1.
//             rw=0 -> RX.
//             rw=1 -> TX: tx_req pulses at the 9th rise, and tx_byte is sampled
//             at the closing fall, where its MSB is driven.
//   RX        shift 8 bits into a shift register.
//             After the 8th rise: rx_byte <= shift, rx_valid pulses once
//             (<= SYNC_STAGES+2 clk after the raw sdc edge), then RX_ACK.
//   RX_ACK    drive sda=0 for the 9th bit, then back to RX. Unlimited byte count.
//   TX        on each sdc fall drive sda = bit ? z : 0, for 8 bits.
//             Release sda at the fall after the 8th bit, then TX_ACK.
//   TX_ACK    sample the controller's sda at the 9th rise:
//             0 = ACK -> tx_req pulse, reload tx_byte at the next fall, back to TX.
//             1 = NACK -> WAIT_STOP.
//   WAIT_STOP sda released; ignore the bus until START or STOP.
//  bit_cnt is 3 bits plus an ack flag. It wraps 7->0 only via an ACK state and
//   never counts in IDLE/WAIT_STOP.
//  A START or STOP during any ACK drive releases sda at once (same clk as detection).
//  Simultaneous reset and bus event: reset wins.
//  sdc/sda glitches shorter than 1 clk are not filtered; bus timing is required.
// CONFIGURATION
//  GENERAL_CALL_EN defined: address 7'h00 with rw=0 also matches; it is ACKed and
//   received like a normal write (addressed=1). Address 7'h00 with rw=1 ->
//   WAIT_STOP, no ACK.
//  Undefined: only PERIPH_ADDR matches; 7'h00 -> WAIT_STOP, no ACK.
// TESTING
//  1 START, addr 0x05 + W, data 0xB5, STOP:
//    sda=0 on both 9th bits, rx_byte=0xB5, exactly one rx_valid, addressed 1 then 0.
//  2 START, addr 0x06 + W, 0xFF:
//    sda never driven 0 by target, no rx_valid, addressed stays 0.
//  3 START, addr 0x05 + R, tx_byte=0x5A, controller ACK, tx_byte=0xC3, controller NACK:
//    line shows 0x5A then 0xC3, two tx_req pulses, sda released after NACK, rw=1.
//  4 Write 0x05 with 4 data bits, then repeated START, addr 0x05 + R:
//    no rx_valid, new address ACKed, rw=1, TX begins.
//  5 Assert reset while the target drives a 0 bit in TX:
//    sda=z and all outputs at reset values in the same cycle; next START works normally.
//  6 Addr 0x00 + W, data 0x11:
//    ACK + rx_byte=0x11 with GENERAL_CALL_EN; no ACK without it.

Source files
------------

// File: rtl/i2c_peripheral.sv
// I2C target: oversampled sdc/sda, START/STOP detection, 7-bit address match, write RX / read TX.
// Optional GENERAL_CALL_EN: also ACK address 7'h00 with rw=0 and receive it as a normal write.
module i2c_peripheral #(
  parameter logic [6:0] PERIPH_ADDR = 7'd5,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sdc,
  inout  wire        sda,
  input  logic [7:0] tx_byte,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       tx_req,
  output logic       addressed,
  output logic       rw
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, WAIT_STOP
  } state_t;

  state_t state, state_n;

  logic [SYNC_STAGES-1:0] sdc_pipe, sda_pipe;
  logic       sdc_s, sda_s, sdc_q, sda_q;
  logic       sdc_rise, sdc_fall, start_det, stop_det;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic       ack, ack_n;
  logic       oe, oe_n;
  logic [7:0] sh, sh_n;
  logic [7:0] rx_byte_n;
  logic       rx_valid_n, tx_req_n, addressed_n, rw_n;
  logic       addr_match;

  // Open-drain: only ever pull low or release.
  assign sda = oe ? 1'b0 : 1'bz;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sdc_pipe <= '1;
      sda_pipe <= '1;
      sdc_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      sdc_pipe <= {sdc_pipe[SYNC_STAGES-2:0], sdc};
      sda_pipe <= {sda_pipe[SYNC_STAGES-2:0], sda};
      sdc_q    <= sdc_s;
      sda_q    <= sda_s;
    end
  end

  assign sdc_s     = sdc_pipe[SYNC_STAGES-1];
  assign sda_s     = sda_pipe[SYNC_STAGES-1];
  assign sdc_rise  =  sdc_s & ~sdc_q;
  assign sdc_fall  = ~sdc_s &  sdc_q;
  assign start_det = sdc_s & sdc_q & ~sda_s &  sda_q;
  assign stop_det  = sdc_s & sdc_q &  sda_s & ~sda_q;

  // After seven address bits sh[6:0] holds the address and sda_s is the R/W bit.
`ifdef GENERAL_CALL_EN
  assign addr_match = (sh[6:0] == PERIPH_ADDR) || ((sh[6:0] == 7'h00) && !sda_s);
`else
  assign addr_match = (sh[6:0] == PERIPH_ADDR);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      ack       <= 1'b0;
      oe        <= 1'b0;
      sh        <= '0;
      rx_byte   <= '0;
      rx_valid  <= 1'b0;
      tx_req    <= 1'b0;
      addressed <= 1'b0;
      rw        <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      ack       <= ack_n;
      oe        <= oe_n;
      sh        <= sh_n;
      rx_byte   <= rx_byte_n;
      rx_valid  <= rx_valid_n;
      tx_req    <= tx_req_n;
      addressed <= addressed_n;
      rw        <= rw_n;
    end
  end

  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    ack_n       = ack;
    oe_n        = oe;
    sh_n        = sh;
    rx_byte_n   = rx_byte;
    rx_valid_n  = 1'b0;
    tx_req_n    = 1'b0;
    addressed_n = addressed;
    rw_n        = rw;
    if (start_det) begin
      state_n     = ADDR;
      bit_cnt_n   = '0;
      ack_n       = 1'b0;
      oe_n        = 1'b0;
      addressed_n = 1'b0;
    end else if (stop_det) begin
      state_n     = IDLE;
      bit_cnt_n   = '0;
      ack_n       = 1'b0;
      oe_n        = 1'b0;
      addressed_n = 1'b0;
    end else begin
      case (state)
        ADDR: if (sdc_rise) begin
          sh_n = {sh[6:0], sda_s};
          if (bit_cnt == 3'd7) begin
            if (addr_match) begin
              state_n     = ADDR_ACK;
              rw_n        = sda_s;
              addressed_n = 1'b1;
            end else begin
              state_n = WAIT_STOP;
            end
          end else begin
            bit_cnt_n = bit_cnt + 3'd1;
          end
        end
        // ack=0: waiting for the fall that starts the ACK drive; ack=1: 9th rise seen.
        ADDR_ACK, RX_ACK: begin
          if (sdc_fall) begin
            if (!ack) begin
              oe_n = 1'b1;
            end else begin
              ack_n     = 1'b0;
              bit_cnt_n = '0;
              if (state == ADDR_ACK && rw) begin
                state_n = TX;
                sh_n    = tx_byte;
                oe_n    = ~tx_byte[7];
              end else begin
                state_n = RX;
                oe_n    = 1'b0;
              end
            end
          end else if (sdc_rise && oe) begin
            ack_n = 1'b1;
            if (state == ADDR_ACK && rw) tx_req_n = 1'b1;
          end
        end
        RX: if (sdc_rise) begin
          sh_n = {sh[6:0], sda_s};
          if (bit_cnt == 3'd7) begin
            rx_byte_n  = {sh[6:0], sda_s};
            rx_valid_n = 1'b1;
            state_n    = RX_ACK;
          end else begin
            bit_cnt_n = bit_cnt + 3'd1;
          end
        end
        TX: begin
          if (sdc_rise) begin
            if (bit_cnt == 3'd7) ack_n = 1'b1;
            else                 bit_cnt_n = bit_cnt + 3'd1;
          end else if (sdc_fall) begin
            if (ack) begin
              ack_n   = 1'b0;
              oe_n    = 1'b0;
              state_n = TX_ACK;
            end else begin
              sh_n = {sh[6:0], 1'b0};
              oe_n = ~sh[6];
            end
          end
        end
        TX_ACK: begin
          if (sdc_rise) begin
            if (!sda_s) begin
              tx_req_n = 1'b1;
              ack_n    = 1'b1;
            end else begin
              state_n   = WAIT_STOP;
              bit_cnt_n = '0;
            end
          end else if (sdc_fall && ack) begin
            ack_n     = 1'b0;
            bit_cnt_n = '0;
            sh_n      = tx_byte;
            oe_n      = ~tx_byte[7];
            state_n   = TX;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
